// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file write-back path.
package regfile_pkg;

  localparam int AW           = 5;
  localparam int DW           = 32;
  localparam int NREQ_DEFAULT = 3;
  localparam int REG_ZERO     = 0;

  // True when two or more of up to eight request lines are active.
  function automatic logic multi_valid(input logic [7:0] v);
    return ($countones(v) > 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;

  // Index reached by stepping j places past p, wrapping at N.
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int j);
    int s;
    s = int'(p) + j;
    if (s >= N) begin
      s = s - N;
    end else begin
      s = s;
    end
    return s[IW-1:0];
  endfunction

  // Search from ptr for the first valid request; grant only when enabled.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[wrap(ptr, j)]) begin
        found     = 1'b1;
        grant_idx = wrap(ptr, j);
      end else begin
        found = found;
      end
    end
    if (en && found) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Write-back arbiter: round-robin grant of NREQ sources onto the single
// registered write port (WE/A3/WD3) of the register file.
module regfile_wb_arb
  import regfile_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int AW   = regfile_pkg::AW,
  parameter int DW   = regfile_pkg::DW,
  parameter int CW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             WE,
  output logic [AW-1:0]    A3,
  output logic [DW-1:0]    WD3,
  output logic [2:0]       grant_id,
  output logic [CW-1:0]    contention_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] gidx;
  logic [NREQ-1:0] grant;
  logic          accept;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // rst_n gates the enable so req_ready is low for the whole reset window.
  rr_arbiter #(.N(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (~hold & rst_n),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Select the winning request's payload and the pointer that follows it.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = (gidx == IW'(i)) ? req_addr[i*AW +: AW] : sel_addr;
      sel_data = (gidx == IW'(i)) ? req_data[i*DW +: DW] : sel_data;
    end
    if (gidx == IW'(NREQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = gidx + 1'b1;
    end
  end

  // Output register and round-robin pointer; x0 writes consume a grant but never assert WE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE       <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      grant_id <= 3'd0;
      rr_ptr   <= '0;
    end else if (accept) begin
      WE       <= (int'(sel_addr) != REG_ZERO);
      A3       <= sel_addr;
      WD3      <= sel_data;
      grant_id <= 3'(gidx);
      rr_ptr   <= next_ptr;
    end else begin
      WE <= 1'b0;
    end
  end

  // Saturating count of cycles with two or more valid requesters, regardless of hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention_cnt <= '0;
    end else if (multi_valid(8'(req_valid)) && (contention_cnt != {CW{1'b1}})) begin
      contention_cnt <= contention_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      contention_cnt <= contention_cnt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb with a queue-based behavioural model.
module tb_regfile_wb_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hold = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_ready;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [2:0]  grant_id;
  logic [15:0] contention_cnt;

  regfile_wb_arb dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .WE(WE), .A3(A3), .WD3(WD3), .grant_id(grant_id), .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Pending requests per source, front = currently presented.
  logic [4:0]  qa[3][$];
  logic [31:0] qd[3][$];

  // Model state.
  int          m_ptr = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_a3 = '0;
  logic [31:0] m_wd3 = '0;
  int          m_gid = 0;
  int          m_cnt = 0;
  logic [31:0] rf[32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    for (int j = 0; j < 3; j++) begin
      if (req_valid[(m_ptr + j) % 3]) return (m_ptr + j) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_ready();
    int w;
    w = winner();
    if (rst_n && !hold && w >= 0) return 3'b001 << w;
    return 3'b000;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < 3; i++) begin
      req_valid[i]          = (qa[i].size() > 0);
      req_addr[i*5 +: 5]    = (qa[i].size() > 0) ? qa[i][0] : 5'd0;
      req_data[i*32 +: 32]  = (qd[i].size() > 0) ? qd[i][0] : 32'd0;
    end
  endtask

  task automatic push(input int i, input logic [4:0] a, input logic [31:0] d);
    qa[i].push_back(a);
    qd[i].push_back(d);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_gid = 0; m_cnt = 0;
  endtask

  task automatic model_update();
    int w;
    if (!rst_n) return;
    if (m_we) rf[m_a3] = m_wd3;
    if ($countones(req_valid) >= 2 && m_cnt != 65535) m_cnt++;
    w = winner();
    if (w >= 0 && !hold) begin
      m_a3  = qa[w][0];
      m_wd3 = qd[w][0];
      m_we  = (qa[w][0] != 5'd0);
      m_gid = w;
      m_ptr = (w + 1) % 3;
      void'(qa[w].pop_front());
      void'(qd[w].pop_front());
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    drive_inputs();
  endtask

  function automatic int pending();
    return qa[0].size() + qa[1].size() + qa[2].size();
  endfunction

  task automatic drain();
    int budget;
    budget = 0;
    while (pending() > 0 && budget < 50) begin
      tick();
      budget++;
    end
    tick();
    chk("drain", 64'(pending()), 64'd0);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 64'(req_ready), 64'(exp_ready()));
      chk("WE", 64'(WE), 64'(m_we));
      chk("A3", 64'(A3), 64'(m_a3));
      chk("WD3", 64'(WD3), 64'(m_wd3));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      chk("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
    end
  end

  initial begin
    int order[6];
    int c0;
    order = '{0, 1, 2, 0, 1, 2};
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;

    // Power-on reset.
    #1 rst_n = 1'b0;
    model_reset();
    #1 chk_en = 1'b1;
    chk("rst_WE", 64'(WE), 64'd0);
    chk("rst_cnt", 64'(contention_cnt), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    tick();

    // Single requester.
    push(1, 5'd5, 32'hDEADBEEF);
    drive_inputs();
    #1 chk("single_ready", 64'(req_ready), 64'b010);
    tick();
    chk("single_WE", 64'(WE), 64'd1);
    chk("single_A3", 64'(A3), 64'd5);
    chk("single_WD3", 64'(WD3), 64'hDEADBEEF);
    chk("single_gid", 64'(grant_id), 64'd1);
    tick();
    chk("single_WE_off", 64'(WE), 64'd0);

    // x0 write from requester 2.
    push(2, 5'd0, 32'h1234);
    drive_inputs();
    #1 chk("x0_ready", 64'(req_ready), 64'b100);
    tick();
    chk("x0_WE", 64'(WE), 64'd0);
    chk("x0_WD3", 64'(WD3), 64'h1234);
    chk("x0_ptr_model", 64'(m_ptr), 64'd0);
    tick();

    // Three-way contention starting at pointer 0.
    c0 = int'(contention_cnt);
    chk("cont_start", 64'(c0), 64'd0);
    for (int n = 0; n < 3; n++)
      for (int i = 0; i < 3; i++) push(i, 5'(8 + i), 32'(i * 16 + n));
    drive_inputs();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("cont_order", 64'(grant_id), 64'(order[k]));
    end
    chk("cont_cnt6", 64'(contention_cnt), 64'd6);
    drain();
    tick();
    chk("cont_cnt_final", 64'(contention_cnt), 64'd8);
    tick();
    chk("cont_cnt_stable", 64'(contention_cnt), 64'd8);

    // hold for 3 cycles with all requesters valid.
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 3; i++) push(i, 5'(16 + i), 32'(32'h100 + i * 16 + n));
    drive_inputs();
    tick();
    chk("hold_pre_gid", 64'(grant_id), 64'd0);
    hold = 1'b1;
    #1 chk("hold_ready", 64'(req_ready), 64'd0);
    chk("hold_inflight_WE", 64'(WE), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_WE", 64'(WE), 64'd0);
    end
    hold = 1'b0;
    #1 chk("release_ready", 64'(req_ready), 64'b010);
    tick();
    chk("release_gid", 64'(grant_id), 64'd1);
    drain();

    // Same address from requesters 0 and 1.
    chk("same_ptr_model", 64'(m_ptr), 64'd0);
    push(0, 5'd7, 32'hA);
    push(1, 5'd7, 32'hB);
    drive_inputs();
    tick();
    chk("same_WD3_first", 64'(WD3), 64'hA);
    tick();
    chk("same_WD3_second", 64'(WD3), 64'hB);
    tick();
    tick();
    chk("same_rf7", 64'(rf[7]), 64'hB);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 3; i++) begin
      push(i, 5'(20 + i), 32'(32'hC0 + i));
      push(i, 5'(24 + i), 32'(32'hD0 + i));
    end
    drive_inputs();
    tick();
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_WE", 64'(WE), 64'd0);
    chk("mid_rst_A3", 64'(A3), 64'd0);
    chk("mid_rst_WD3", 64'(WD3), 64'd0);
    chk("mid_rst_cnt", 64'(contention_cnt), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_gid", 64'(grant_id), 64'd0);
    drain();
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
